// File: rtl/n_bit_sqrt.sv
// Iterative restoring integer square root: 2N-bit radicand -> N-bit floor(sqrt) plus N+1-bit remainder.
// Define SQRT_CHECK_EN to add the chk_err port, which re-squares each result and flags any inconsistency.
module n_bit_sqrt #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] radicand,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   root,
    output logic [N:0]     remainder
`ifdef SQRT_CHECK_EN
    ,
    output logic           chk_err
`endif
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2*N-1:0]  r_sreg;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_root;
    logic [CW-1:0]   r_cnt;

    logic [N+2:0]    w_rprime;
    logic [N+2:0]    w_sub;
    logic            w_ge;
    logic [N:0]      w_t;
    logic [N:0]      w_rem_next;
    logic [N-1:0]    w_root_next;
    logic            w_accept;

    // One restoring step: bring down the next two radicand bits, try subtracting {root, 01}.
    assign w_rprime    = {r_rem, r_sreg[2*N-1 -: 2]};
    assign w_sub       = {1'b0, r_root, 2'b01};
    assign w_ge        = (w_rprime >= w_sub);
    assign w_t         = w_rprime[N:0] - w_sub[N:0];
    assign w_rem_next  = w_ge ? w_t : w_rprime[N:0];
    assign w_root_next = {r_root[N-2:0], w_ge};

    assign w_accept = start && (r_state != S_CALC);

    // NOTE: every register uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC);
        done = (r_state == S_DONE);
    end

`ifdef SQRT_CHECK_EN
    logic [2*N-1:0] r_cap;
    logic [2*N-1:0] w_sq;
    logic [2*N:0]   w_sum;
    logic           w_err;

    // Same N x N product the squarer computes, then add the remainder back.
    assign w_sq  = {{N{1'b0}}, w_root_next} * {{N{1'b0}}, w_root_next};
    assign w_sum = {1'b0, w_sq} + {{N{1'b0}}, w_rem_next};
    assign w_err = (w_sum != {1'b0, r_cap}) || (w_rem_next > {w_root_next, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cap <= radicand;
            end
            if ((r_state == S_CALC) && (r_cnt == '0)) begin
                chk_err <= w_err;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg    <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            root      <= '0;
            remainder <= '0;
        end else if (w_accept) begin
            r_sreg <= radicand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CNT_INIT;
        end else if (r_state == S_CALC) begin
            r_sreg <= r_sreg << 2;
            r_rem  <= w_rem_next;
            r_root <= w_root_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                root      <= w_root_next;
                remainder <= w_rem_next;
            end
        end
    end

endmodule

// File: tb/tb_n_bit_sqrt.sv
// Self-checking bench for n_bit_sqrt (N=8): directed vector table, multi-cycle corner sequences,
// and random radicands checked against a floor(sqrt) reference computed by plain arithmetic.
module tb_n_bit_sqrt;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*N-1:0] radicand = '0;
    logic           busy;
    logic           done;
    logic [N-1:0]   root;
    logic [N:0]     remainder;
`ifdef SQRT_CHECK_EN
    logic           chk_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    n_bit_sqrt #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .radicand  (radicand),
        .busy      (busy),
        .done      (done),
        .root      (root),
        .remainder (remainder)
`ifdef SQRT_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2*N-1:0] rad;
        logic [N-1:0]   exp_root;
        logic [N:0]     exp_rem;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_sqrt(input int x, output int r, output int rem);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        rem = x - r * r;
    endfunction

    task automatic check_result(input string name, input int exp_root, input int exp_rem);
        check({name, ".root"}, 32'(root), exp_root);
        check({name, ".rem"}, 32'(remainder), exp_rem);
`ifdef SQRT_CHECK_EN
        check({name, ".chk_err"}, 32'(chk_err), 0);
`endif
    endtask

    // Called at a negedge with the DUT idle or in DONE; returns at the negedge where done is seen.
    task automatic run_op(input logic [2*N-1:0] rad, output int lat, output int busy_cyc, output bit got);
        lat = -1;
        busy_cyc = 0;
        got = 1'b0;
        radicand = rad;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                radicand = 16'($urandom);
            end
            if (done) begin
                got = 1'b1;
                lat = i;
            end else if (busy) begin
                busy_cyc++;
            end
        end
    endtask

    task automatic op_and_check(input string name, input logic [2*N-1:0] rad, input int er, input int erem);
        int lat, bc;
        bit got;
        run_op(rad, lat, bc, got);
        check({name, ".done_seen"}, 32'(got), 1);
        check({name, ".latency"}, lat, N);
        check({name, ".busy_cycles"}, bc, N);
        check_result(name, er, erem);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[$];
        int   r, rem, ndone, nbusy, lat, bc, last_cyc;
        bit   got;
        logic [2*N-1:0] b2b_rad[3];

        vecs.push_back('{16'd0,     8'd0,   9'd0});
        vecs.push_back('{16'd144,   8'd12,  9'd0});
        vecs.push_back('{16'd200,   8'd14,  9'd4});
        vecs.push_back('{16'd65535, 8'd255, 9'd510});
        vecs.push_back('{16'd1,     8'd1,   9'd0});
        vecs.push_back('{16'd2,     8'd1,   9'd1});
        vecs.push_back('{16'd3,     8'd1,   9'd2});
        vecs.push_back('{16'd4,     8'd2,   9'd0});
        vecs.push_back('{16'd65025, 8'd255, 9'd0});
        vecs.push_back('{16'd65024, 8'd254, 9'd508});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.root", 32'(root), 0);
        check("reset.rem", 32'(remainder), 0);
`ifdef SQRT_CHECK_EN
        check("reset.chk_err", 32'(chk_err), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].rad, vecs[i].exp_root, vecs[i].exp_rem);
            repeat (i % 3) @(negedge clk);
        end

        // Start pulse during CALC must be ignored
        @(negedge clk);
        radicand = 16'd144;
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                radicand = 16'd9;
            end
            if (i == 4) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                check_result("ignore_start", 12, 0);
            end
        end
        check("ignore_start.done_count", ndone, 1);
        check("ignore_start.busy_cycles", nbusy, N);

        // Reset in the middle of CALC
        radicand = 16'd200;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset.busy", 32'(busy), 0);
        check("midreset.done", 32'(done), 0);
        check("midreset.root", 32'(root), 0);
        check("midreset.rem", 32'(remainder), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset.no_done", ndone, 0);
        op_and_check("after_reset", 16'd49, 7, 0);
        @(negedge clk);

        // Start held high: back-to-back loads from DONE
        b2b_rad[0] = 16'd100;
        b2b_rad[1] = 16'd99;
        b2b_rad[2] = 16'd0;
        radicand = b2b_rad[0];
        start = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            check($sformatf("b2b%0d.done_seen", k), 32'(got), 1);
            ref_sqrt(int'(b2b_rad[k]), r, rem);
            check_result($sformatf("b2b%0d", k), r, rem);
            if (k > 0) check($sformatf("b2b%0d.spacing", k), cyc - last_cyc, N + 1);
            last_cyc = cyc;
            if (k < 2) radicand = b2b_rad[k + 1];
            else start = 1'b0;
        end
        @(negedge clk);

        // Random radicands vs. reference model
        for (int k = 0; k < 300; k++) begin
            logic [2*N-1:0] x;
            x = 16'($urandom);
            if (k % 10 == 0) x = 16'($urandom_range(0, 300));
            ref_sqrt(int'(x), r, rem);
            run_op(x, lat, bc, got);
            check($sformatf("rnd%0d.done_seen", k), 32'(got), 1);
            check_result($sformatf("rnd%0d(x=%0d)", k, x), r, rem);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
